exec_datapath: RTL and testbench

Execution and memory datapath driven by the control unit's decoded control bus (operand1, operand2, offset, opcode, sel1, sel3, w_r). It returns result2 to the control unit for register-file write-back. The block contains:
- a registered ALU;
- a 32×8 synchronous data memory addressed as base + offset;
- a registered result mux selecting ALU or memory data.

It is the responder end of the control-unit/datapath interface.

---
 rtl/cpu_pkg.sv | 41 ++++
 rtl/exec_alu.sv | 59 +++++
 rtl/exec_datapath.sv | 76 +++++++
 tb/tb_exec_datapath.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the control unit / execution datapath pair:
// widths, ALU opcodes, instruction classes and control-unit states.
package cpu_pkg;

  localparam int DATA_WIDTH  = 8;
  localparam int ADDR_BITS   = 5;
  localparam int INSTR_WIDTH = 16;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_AND    = 4'b0010;
  localparam logic [3:0] OP_OR     = 4'b0011;
  localparam logic [3:0] OP_XOR    = 4'b0100;
  localparam logic [3:0] OP_NOT    = 4'b0101;
  localparam logic [3:0] OP_SHL    = 4'b0110;
  localparam logic [3:0] OP_SHR    = 4'b0111;
  localparam logic [3:0] OP_PASS_A = 4'b1000;
  localparam logic [3:0] OP_PASS_B = 4'b1001;
  localparam logic [3:0] OP_NOP    = 4'b1111;

  typedef enum logic [1:0] {
    CLS_NONE    = 2'b00,
    CLS_STD_OP  = 2'b01,
    CLS_LOAD_R  = 2'b10,
    CLS_STORE_R = 2'b11
  } instr_class_t;

  typedef enum logic [2:0] {
    CU_FETCH      = 3'd0,
    CU_DECODE     = 3'd1,
    CU_EXECUTE    = 3'd2,
    CU_MEMORY     = 3'd3,
    CU_WRITE_BACK = 3'd4
  } cu_state_t;

  // Only the arithmetic and shift operations produce a meaningful carry.
  function automatic logic op_has_carry(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU: result, carry/borrow/shifted-out bit, and whether
// the operation is allowed to update the zero/carry flags (all but NOP).
module exec_alu
  import cpu_pkg::*;
#(
  parameter int W = cpu_pkg::DATA_WIDTH
) (
  input  logic [3:0]   opcode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic         updates_flags
);

  logic [W:0]     wide;
  logic [2*W-1:0] shifted;

  // Shifts go through a double-width vector so the last bit pushed out
  // lands at a fixed position next to the result.
  always_comb begin
    result        = '0;
    carry_out     = 1'b0;
    updates_flags = 1'b1;
    wide          = '0;
    shifted       = '0;
    case (opcode)
      OP_ADD: begin
        wide      = {1'b0, a} + {1'b0, b};
        result    = wide[W-1:0];
        carry_out = wide[W];
      end
      OP_SUB: begin
        wide      = {1'b0, a} - {1'b0, b};
        result    = wide[W-1:0];
        carry_out = wide[W];
      end
      OP_AND:    result = a & b;
      OP_OR:     result = a | b;
      OP_XOR:    result = a ^ b;
      OP_NOT:    result = ~a;
      OP_SHL: begin
        shifted   = {{W{1'b0}}, a} << b[2:0];
        result    = shifted[W-1:0];
        carry_out = shifted[W];
      end
      OP_SHR: begin
        shifted   = {a, {W{1'b0}}} >> b[2:0];
        result    = shifted[2*W-1:W];
        carry_out = shifted[W-1];
      end
      OP_PASS_A: result = a;
      OP_PASS_B: result = b;
      OP_NOP:    updates_flags = 1'b0;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/exec_datapath.sv
// Execution/memory datapath: registered ALU, 32x8 data memory addressed as
// base + offset, and a result mux fed only from pipeline registers.
module exec_datapath
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  parameter int ADDR_BITS  = cpu_pkg::ADDR_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  input  logic [DATA_WIDTH-1:0] offset,
  input  logic [3:0]            opcode,
  input  logic                  sel1,
  input  logic                  sel3,
  input  logic                  w_r,
  output logic [DATA_WIDTH-1:0] result2,
  output logic                  zero,
  output logic                  carry
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] alu_q;
  logic [DATA_WIDTH-1:0] mem_q;
  logic                  sel1_q;

  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_carry;
  logic                  alu_updates;
  logic [DATA_WIDTH-1:0] addr_sum;
  logic [ADDR_BITS-1:0]  addr;
  logic                  unused_addr_bits;

  exec_alu #(.W(DATA_WIDTH)) u_alu (
    .opcode        (opcode),
    .a             (operand1),
    .b             (operand2),
    .result        (alu_result),
    .carry_out     (alu_carry),
    .updates_flags (alu_updates)
  );

  // The address wraps within the memory; upper sum bits are discarded.
  assign addr_sum         = operand1 + (sel3 ? offset : '0);
  assign addr             = addr_sum[ADDR_BITS-1:0];
  assign unused_addr_bits = ^addr_sum[DATA_WIDTH-1:ADDR_BITS];

  // The memory array shares the reset-sensitive block so that a write on an
  // edge with reset held is simply skipped; its contents are never cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_q  <= '0;
      mem_q  <= '0;
      sel1_q <= 1'b1;
      zero   <= 1'b0;
      carry  <= 1'b0;
    end else begin
      alu_q  <= alu_result;
      mem_q  <= mem[addr];
      sel1_q <= sel1;
      if (alu_updates) begin
        zero  <= (alu_result == '0);
        carry <= op_has_carry(opcode) ? alu_carry : 1'b0;
      end
      if (w_r) begin
        mem[addr] <= operand2;
      end
    end
  end

  assign result2 = sel1_q ? alu_q : mem_q;

endmodule

// File: tb/tb_exec_datapath.sv
// Scoreboard bench for exec_datapath: stimulus pushes expectations computed
// by an arithmetic reference model, a monitor pops them after each edge.
module tb_exec_datapath;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] operand1 = '0;
  logic [7:0] operand2 = '0;
  logic [7:0] offset = '0;
  logic [3:0] opcode = 4'hF;
  logic       sel1 = 1'b1;
  logic       sel3 = 1'b0;
  logic       w_r = 1'b0;
  logic [7:0] result2;
  logic       zero;
  logic       carry;

  typedef struct {
    logic [7:0] result;
    logic       zero;
    logic       carry;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [7:0] model_mem [32];
  bit         model_zero = 0;
  bit         model_carry = 0;

  exec_datapath dut (
    .clk      (clk),
    .rst      (rst),
    .operand1 (operand1),
    .operand2 (operand2),
    .offset   (offset),
    .opcode   (opcode),
    .sel1     (sel1),
    .sel3     (sel3),
    .w_r      (w_r),
    .result2  (result2),
    .zero     (zero),
    .carry    (carry)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Reference ALU in plain integer arithmetic.
  function automatic void alu_model(input int opc, input int a, input int b,
                                    output int res, output bit c, output bit upd);
    int s;
    s   = b % 8;
    res = 0;
    c   = 0;
    upd = 1;
    case (opc)
      0: begin res = (a + b) % 256; c = (a + b) > 255; end
      1: begin res = (a - b + 256) % 256; c = a < b; end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = 255 - a;
      6: begin res = (a * (1 << s)) % 256; c = (s > 0) ? ((a >> (8 - s)) % 2 == 1) : 0; end
      7: begin res = a >> s; c = (s > 0) ? ((a >> (s - 1)) % 2 == 1) : 0; end
      8: res = a;
      9: res = b;
      15: upd = 0;
      default: res = 0;
    endcase
  endfunction

  task automatic apply_stimulus(input int a, input int b, input int off, input int opc,
                                input bit s1, input bit s3, input bit wr, input string name);
    int   res;
    int   addr;
    bit   c;
    bit   upd;
    exp_t e;
    @(negedge clk);
    operand1 = a[7:0];
    operand2 = b[7:0];
    offset   = off[7:0];
    opcode   = opc[3:0];
    sel1     = s1;
    sel3     = s3;
    w_r      = wr;
    alu_model(a, b, opc, res, c, upd);
    alu_model(opc, a, b, res, c, upd);
    addr = (a + (s3 ? off : 0)) % 32;
    e.result = s1 ? res[7:0] : model_mem[addr];
    if (upd) begin
      model_zero  = (res == 0);
      model_carry = c;
    end
    e.zero  = model_zero;
    e.carry = model_carry;
    e.name  = name;
    if (wr) model_mem[addr] = b[7:0];
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_output({e.name, ".result2"}, result2, e.result);
        check_output({e.name, ".zero"}, zero, e.zero);
        check_output({e.name, ".carry"}, carry, e.carry);
      end
    end
  end

  initial begin : stimulus
    int budget;
    repeat (2) @(negedge clk);
    check_output("reset.result2", result2, 0);
    check_output("reset.zero", zero, 0);
    check_output("reset.carry", carry, 0);
    rst = 1'b1;

    // Give every memory word a known value before any reads.
    for (int i = 0; i < 32; i++)
      apply_stimulus(i, (i * 37 + 11) % 256, 0, 9, 1, 0, 1, "init");

    apply_stimulus(5, 3, 0, 0, 1, 0, 0, "add_5_3");
    apply_stimulus(3, 5, 0, 1, 1, 0, 0, "sub_3_5");
    repeat (3) apply_stimulus(4, 8'hAA, 2, 0, 1, 1, 1, "store_6");
    apply_stimulus(4, 0, 2, 0, 0, 1, 0, "load_6");
    apply_stimulus(30, 8'h5C, 5, 8, 1, 1, 1, "store_wrap");
    apply_stimulus(3, 0, 0, 8, 0, 0, 0, "load_wrap");
    apply_stimulus(9, 8'h11, 0, 9, 1, 0, 1, "rdw_setup");
    apply_stimulus(9, 8'h22, 0, 9, 0, 0, 1, "rdw_old");
    apply_stimulus(9, 8'h22, 0, 9, 0, 0, 0, "rdw_new");
    apply_stimulus(8'h81, 1, 0, 6, 1, 0, 0, "shl_carry");
    apply_stimulus(8'h01, 1, 0, 7, 1, 0, 0, "shr_carry");
    apply_stimulus(0, 0, 0, 0, 1, 0, 0, "add_zero");
    apply_stimulus(7, 9, 0, 15, 1, 0, 0, "nop_hold");
    apply_stimulus(3, 200, 0, 1, 1, 0, 0, "sub_borrow");
    apply_stimulus(7, 9, 0, 15, 1, 0, 0, "nop_hold_carry");
    @(posedge clk);
    #2;

    // Reset arrives between edges while a store to address 7 is pending.
    @(negedge clk);
    operand1 = 8'd7;
    operand2 = 8'h33;
    sel3     = 1'b0;
    sel1     = 1'b1;
    opcode   = 4'h0;
    w_r      = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check_output("midstore.result2", result2, 0);
    check_output("midstore.zero", zero, 0);
    check_output("midstore.carry", carry, 0);
    @(posedge clk);
    @(negedge clk);
    w_r = 1'b0;
    rst = 1'b1;
    model_zero  = 0;
    model_carry = 0;
    apply_stimulus(7, 0, 0, 15, 0, 0, 0, "midstore_mem7");

    for (int i = 0; i < 300; i++)
      apply_stimulus($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                     $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), "random");

    @(negedge clk);
    w_r = 1'b0;
    budget = 10;
    while (sb.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
